// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt-entry sequencer.
package irq_pkg;

  localparam int unsigned FLAGS_W           = 3;
  localparam int unsigned STACK_FRAME_WORDS = 3;
  localparam logic [31:0] VEC_ADDR_DEFAULT  = 32'h0000_0000;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_PUSH_PCH,
    ST_PUSH_PCL,
    ST_PUSH_FLG,
    ST_VEC_HI,
    ST_VEC_LO,
    ST_VEC_WAIT,
    ST_LOAD
  } irq_state_t;

endpackage

// File: rtl/irq_edge_latch.sv
// Rising-edge detector on the interrupt line with a sticky pending request.
module irq_edge_latch (
  input  logic clk,
  input  logic reset,
  input  logic interrupt,
  input  logic pending_clr,
  output logic int_edge_c,
  output logic pending
);

  logic int_q;

  assign int_edge_c = interrupt & ~int_q;

  // Clear wins over set so an edge that starts a sequence is not remembered twice.
  always_ff @(posedge clk) begin
    if (reset) begin
      int_q   <= 1'b0;
      pending <= 1'b0;
    end else begin
      int_q <= interrupt;
      if (pending_clr) begin
        pending <= 1'b0;
      end else if (int_edge_c) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt entry: drain pipeline, push PC/flags frame, fetch vector, redirect PC.
module interrupt_sequencer
  import irq_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter logic [31:0] VEC_ADDR     = VEC_ADDR_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               interrupt,
  input  logic [31:0]        ret_pc,
  input  logic [FLAGS_W-1:0] flags_in,
  input  logic [31:0]        sp_in,
  input  logic               mem_gnt,
  input  logic [15:0]        mem_rdata,
  output logic               stall_fetch,
  output logic               mem_req,
  output logic               mem_we,
  output logic [31:0]        mem_addr,
  output logic [15:0]        mem_wdata,
  output logic               sp_we,
  output logic [31:0]        sp_wdata,
  output logic               pc_load,
  output logic [31:0]        pc_load_value,
  output logic               int_ack
);

  localparam int unsigned      CNT_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

  irq_state_t         state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [31:0]        pc_r, pc_n, sp_r, sp_n;
  logic [FLAGS_W-1:0] flg_r, flg_n;
  logic [15:0]        vec_hi, vec_hi_n, vec_lo_n;
  logic               hi_taken, hi_taken_n;
  logic               int_edge_c, pending, pending_clr_c;

  logic               stall_n, req_n, we_n, pc_load_n, sp_we_n, ack_n;
  logic [31:0]        addr_n, pcv_n, spw_n;
  logic [15:0]        wdata_n;

  assign pending_clr_c = (state == ST_IDLE) && (int_edge_c || pending);

  irq_edge_latch u_edge (
    .clk        (clk),
    .reset      (reset),
    .interrupt  (interrupt),
    .pending_clr(pending_clr_c),
    .int_edge_c (int_edge_c),
    .pending    (pending)
  );

  // Next state, datapath captures, and the Moore outputs of the next state.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    pc_n       = pc_r;
    sp_n       = sp_r;
    flg_n      = flg_r;
    vec_hi_n   = vec_hi;
    vec_lo_n   = 16'h0000;
    hi_taken_n = hi_taken;

    unique case (state)
      ST_IDLE: begin
        if (int_edge_c || pending) begin
          state_n = ST_DRAIN;
          cnt_n   = '0;
        end
      end
      ST_DRAIN: begin
        if (cnt == CNT_LAST) begin
          pc_n    = ret_pc;
          flg_n   = flags_in;
          sp_n    = sp_in;
          state_n = ST_PUSH_PCH;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_PUSH_PCH: if (mem_req && mem_gnt) state_n = ST_PUSH_PCL;
      ST_PUSH_PCL: if (mem_req && mem_gnt) state_n = ST_PUSH_FLG;
      ST_PUSH_FLG: if (mem_req && mem_gnt) state_n = ST_VEC_HI;
      ST_VEC_HI: begin
        if (mem_req && mem_gnt) begin
          state_n    = ST_VEC_LO;
          hi_taken_n = 1'b0;
        end
      end
      ST_VEC_LO: begin
        // Read data for the high half is only valid on the first VEC_LO cycle.
        if (!hi_taken) begin
          vec_hi_n   = mem_rdata;
          hi_taken_n = 1'b1;
        end
        if (mem_req && mem_gnt) state_n = ST_VEC_WAIT;
      end
      ST_VEC_WAIT: begin
        vec_lo_n = mem_rdata;
        state_n  = ST_LOAD;
      end
      ST_LOAD: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    stall_n   = (state_n != ST_IDLE);
    req_n     = 1'b0;
    we_n      = 1'b0;
    addr_n    = 32'h0;
    wdata_n   = 16'h0;
    pc_load_n = 1'b0;
    pcv_n     = 32'h0;
    sp_we_n   = 1'b0;
    spw_n     = 32'h0;
    ack_n     = 1'b0;

    case (state_n)
      ST_PUSH_PCH: begin
        req_n = 1'b1; we_n = 1'b1; addr_n = sp_n;         wdata_n = pc_n[31:16];
      end
      ST_PUSH_PCL: begin
        req_n = 1'b1; we_n = 1'b1; addr_n = sp_n - 32'd1; wdata_n = pc_n[15:0];
      end
      ST_PUSH_FLG: begin
        req_n = 1'b1; we_n = 1'b1; addr_n = sp_n - 32'd2; wdata_n = 16'(flg_n);
      end
      ST_VEC_HI: begin
        req_n = 1'b1; addr_n = VEC_ADDR;
      end
      ST_VEC_LO: begin
        req_n = 1'b1; addr_n = VEC_ADDR + 32'd1;
      end
      ST_LOAD: begin
        pc_load_n = 1'b1;
        pcv_n     = {vec_hi_n, vec_lo_n};
        sp_we_n   = 1'b1;
        spw_n     = sp_n - 32'(STACK_FRAME_WORDS);
        ack_n     = 1'b1;
      end
      default: ;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      pc_r          <= 32'h0;
      sp_r          <= 32'h0;
      flg_r         <= '0;
      vec_hi        <= 16'h0;
      hi_taken      <= 1'b0;
      stall_fetch   <= 1'b0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= 32'h0;
      mem_wdata     <= 16'h0;
      pc_load       <= 1'b0;
      pc_load_value <= 32'h0;
      sp_we         <= 1'b0;
      sp_wdata      <= 32'h0;
      int_ack       <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      pc_r          <= pc_n;
      sp_r          <= sp_n;
      flg_r         <= flg_n;
      vec_hi        <= vec_hi_n;
      hi_taken      <= hi_taken_n;
      stall_fetch   <= stall_n;
      mem_req       <= req_n;
      mem_we        <= we_n;
      mem_addr      <= addr_n;
      mem_wdata     <= wdata_n;
      pc_load       <= pc_load_n;
      pc_load_value <= pcv_n;
      sp_we         <= sp_we_n;
      sp_wdata      <= spw_n;
      int_ack       <= ack_n;
    end
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboard bench for interrupt_sequencer with a frame-level reference model.
module tb_interrupt_sequencer;

  localparam int unsigned DRAIN = 4;
  localparam logic [31:0] VEC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, interrupt, mem_gnt;
  logic [31:0] ret_pc, sp_in;
  logic [2:0]  flags_in;
  logic [15:0] mem_rdata;
  logic        stall_fetch, mem_req, mem_we, sp_we, pc_load, int_ack;
  logic [31:0] mem_addr, sp_wdata, pc_load_value;
  logic [15:0] mem_wdata;

  interrupt_sequencer #(.DRAIN_CYCLES(DRAIN), .VEC_ADDR(VEC)) dut (
    .clk(clk), .reset(reset), .interrupt(interrupt), .ret_pc(ret_pc),
    .flags_in(flags_in), .sp_in(sp_in), .mem_gnt(mem_gnt), .mem_rdata(mem_rdata),
    .stall_fetch(stall_fetch), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .sp_we(sp_we), .sp_wdata(sp_wdata),
    .pc_load(pc_load), .pc_load_value(pc_load_value), .int_ack(int_ack)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Two memories: one written by observed DUT traffic, one by the model.
  logic [15:0] phys_mem [logic [31:0]];
  logic [15:0] ref_mem  [logic [31:0]];

  function automatic logic [15:0] phys_rd(input logic [31:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : 16'h0000;
  endfunction

  function automatic logic [15:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
  endfunction

  typedef struct {
    bit          is_load;
    logic [31:0] addr;
    logic [15:0] data;
    logic [31:0] pc;
    logic [31:0] sp;
  } exp_t;
  exp_t exp_q[$];

  // One serviced interrupt: three-word frame stored downward from sp, then vector fetch.
  task automatic model_entry(input logic [31:0] pc, input logic [2:0] fl, input logic [31:0] sp);
    exp_t e;
    logic [15:0] frame [3];
    frame[0] = pc[31:16];
    frame[1] = pc[15:0];
    frame[2] = {13'b0, fl};
    for (int i = 0; i < 3; i++) begin
      e.is_load = 1'b0;
      e.addr    = sp - 32'(i);
      e.data    = frame[i];
      e.pc      = 32'h0;
      e.sp      = 32'h0;
      ref_mem[e.addr] = e.data;
      exp_q.push_back(e);
    end
    e.is_load = 1'b1;
    e.addr    = 32'h0;
    e.data    = 16'h0;
    e.pc      = {ref_rd(VEC), ref_rd(VEC + 32'd1)};
    e.sp      = sp - 32'd3;
    exp_q.push_back(e);
  endtask

  // Memory/arbiter model: grant policy and read data one cycle after a granted read.
  int          pcl_wait = 0;
  int          lo_wait  = 0;
  logic [31:0] stall_sp = 32'h0;
  bit          rand_gnt = 1'b0;
  logic        d_rd = 1'b0;
  logic [31:0] d_addr = 32'h0;

  initial begin
    mem_gnt   = 1'b1;
    mem_rdata = 16'h0;
    forever begin
      @(posedge clk);
      #1;
      if (d_rd) mem_rdata = phys_rd(d_addr);
      else      mem_rdata = 16'($urandom);
      if (mem_req && mem_we && mem_addr == stall_sp - 32'd1 && pcl_wait > 0) begin
        mem_gnt = 1'b0; pcl_wait--;
      end else if (mem_req && !mem_we && mem_addr == VEC + 32'd1 && lo_wait > 0) begin
        mem_gnt = 1'b0; lo_wait--;
      end else if (rand_gnt) begin
        mem_gnt = ($urandom_range(0, 3) != 0);
      end else begin
        mem_gnt = 1'b1;
      end
      d_rd   = mem_req && mem_gnt && !mem_we && !reset;
      d_addr = mem_addr;
    end
  end

  // Monitor: pops the scoreboard on every accepted write and every PC load.
  int          ack_cnt = 0;
  int          ack_cyc = 0;
  logic [31:0] last_pc = 32'h0;
  logic [31:0] last_sp = 32'h0;
  logic        p_req = 1'b0, p_gnt = 1'b0, p_we = 1'b0;
  logic [31:0] p_addr = 32'h0;
  logic [15:0] p_wd = 16'h0;
  exp_t        mon_e;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        p_req = 1'b0;
      end else begin
        if (p_req && !p_gnt) begin
          chk("hold_req", mem_req, 1);
          chk("hold_addr", mem_addr, p_addr);
          chk("hold_wdata", mem_wdata, p_wd);
          chk("hold_we", mem_we, p_we);
        end
        if (mem_req && mem_gnt && mem_we) begin
          phys_mem[mem_addr] = mem_wdata;
          if (exp_q.size() == 0) begin
            chk("unexpected_write", 1, 0);
          end else begin
            mon_e = exp_q.pop_front();
            chk("write_kind", mon_e.is_load, 0);
            chk("write_addr", mem_addr, mon_e.addr);
            chk("write_data", mem_wdata, mon_e.data);
          end
        end
        if (pc_load || sp_we || int_ack) begin
          chk("load_strobes", {pc_load, sp_we, int_ack}, 3'b111);
          ack_cnt++;
          ack_cyc = cyc;
          last_pc = pc_load_value;
          last_sp = sp_wdata;
          if (exp_q.size() == 0) begin
            chk("unexpected_load", 1, 0);
          end else begin
            mon_e = exp_q.pop_front();
            chk("load_kind", mon_e.is_load, 1);
            chk("pc_load_value", pc_load_value, mon_e.pc);
            chk("sp_wdata", sp_wdata, mon_e.sp);
          end
        end
        if (mem_req || pc_load) chk("stall_when_busy", stall_fetch, 1);
        p_req  = mem_req;
        p_gnt  = mem_gnt;
        p_we   = mem_we;
        p_addr = mem_addr;
        p_wd   = mem_wdata;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse();
    interrupt = 1'b1;
    step(1);
    interrupt = 1'b0;
  endtask

  task automatic wait_acks(input int target, input int budget);
    int k = 0;
    while (ack_cnt < target && k < budget) begin
      step(1);
      k++;
    end
    if (ack_cnt < target) chk("ack_timeout", ack_cnt, target);
  endtask

  task automatic wait_mem(input logic we, input logic [31:0] a, input string name);
    int k = 0;
    while (!(mem_req && mem_we == we && mem_addr == a) && k < 60) begin
      step(1);
      k++;
    end
    if (k >= 60) chk(name, 0, 1);
  endtask

  task automatic set_inputs(input logic [31:0] pc, input logic [2:0] fl, input logic [31:0] sp);
    ret_pc = pc; flags_in = fl; sp_in = sp;
  endtask

  int e0, c1, base;

  initial begin
    reset = 1'b1;
    interrupt = 1'b0;
    set_inputs(32'h0, 3'b0, 32'h0);
    phys_mem[VEC] = 16'h0000; phys_mem[VEC + 32'd1] = 16'h0040;
    ref_mem[VEC]  = 16'h0000; ref_mem[VEC + 32'd1]  = 16'h0040;
    step(3);
    chk("reset_ctrl", {stall_fetch, mem_req, mem_we, pc_load, sp_we, int_ack}, 6'b0);
    chk("reset_addr", mem_addr, 0);
    chk("reset_wdata", mem_wdata, 0);
    chk("reset_pcv", pc_load_value, 0);
    chk("reset_spw", sp_wdata, 0);
    reset = 1'b0;
    step(2);

    // Basic entry with grant tied high.
    set_inputs(32'h0000_0123, 3'b101, 32'h0000_07FF);
    model_entry(ret_pc, flags_in, sp_in);
    e0 = cyc + 1;
    pulse();
    wait_acks(1, 50);
    chk("basic_latency", ack_cyc - e0, 10);
    chk("basic_pc", last_pc, 32'h0000_0040);
    chk("basic_sp", last_sp, 32'h0000_07FC);
    chk("basic_mem7ff", phys_rd(32'h7FF), 16'h0000);
    chk("basic_mem7fe", phys_rd(32'h7FE), 16'h0123);
    chk("basic_mem7fd", phys_rd(32'h7FD), 16'h0005);
    chk("basic_idle_after", {stall_fetch, int_ack, pc_load}, 3'b000);
    step(3);

    // Grant withheld 3 cycles in PUSH_PCL and 2 in VEC_LO.
    stall_sp = sp_in;
    pcl_wait = 3;
    lo_wait  = 2;
    model_entry(ret_pc, flags_in, sp_in);
    e0 = cyc + 1;
    pulse();
    wait_acks(2, 60);
    chk("stall_latency", ack_cyc - e0, 15);
    chk("stall_used", {pcl_wait[7:0], lo_wait[7:0]}, 16'h0);
    chk("stall_pc", last_pc, 32'h0000_0040);
    step(3);

    // Level-held interrupt services only once.
    base = ack_cnt;
    set_inputs(32'h1234_5678, 3'b010, 32'h0000_0500);
    model_entry(ret_pc, flags_in, sp_in);
    interrupt = 1'b1;
    step(40);
    interrupt = 1'b0;
    step(20);
    chk("level_acks", ack_cnt - base, 1);

    // Nested edge during PUSH_FLG.
    base = ack_cnt;
    set_inputs(32'h0BAD_F00D, 3'b111, 32'h0000_0900);
    model_entry(ret_pc, flags_in, sp_in);
    pulse();
    wait_mem(1'b1, sp_in - 32'd2, "nest_reach_flg");
    model_entry(ret_pc, flags_in, sp_in);
    pulse();
    wait_acks(base + 1, 60);
    c1 = ack_cyc;
    chk("nest_idle_gap", stall_fetch, 0);
    step(1);
    chk("nest_restart", stall_fetch, 1);
    wait_acks(base + 2, 60);
    chk("nest_spacing", ack_cyc - c1, 12);
    step(20);
    chk("nest_acks", ack_cnt - base, 2);

    // Reset during VEC_HI abandons the sequence.
    base = ack_cnt;
    set_inputs(32'h00C0_FFEE, 3'b001, 32'h0000_0A00);
    model_entry(ret_pc, flags_in, sp_in);
    pulse();
    wait_mem(1'b0, VEC, "rst_reach_vechi");
    reset = 1'b1;
    step(1);
    chk("rst_ctrl", {stall_fetch, mem_req, mem_we, pc_load, sp_we, int_ack}, 6'b0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_pcv", pc_load_value, 0);
    reset = 1'b0;
    chk("rst_frame_done", exp_q.size(), 1);
    exp_q.delete();
    step(15);
    chk("rst_no_load", ack_cnt - base, 0);
    model_entry(ret_pc, flags_in, sp_in);
    e0 = cyc + 1;
    pulse();
    wait_acks(base + 1, 50);
    chk("rst_fresh_latency", ack_cyc - e0, 10);
    step(2);

    // Randomized entries with random grant behaviour.
    rand_gnt = 1'b1;
    for (int n = 0; n < 15; n++) begin
      base = ack_cnt;
      set_inputs($urandom, 3'($urandom), $urandom);
      model_entry(ret_pc, flags_in, sp_in);
      pulse();
      wait_acks(base + 1, 300);
      step($urandom_range(1, 3));
    end
    rand_gnt = 1'b0;
    step(3);

    // Stack pointer wrap; the frame overwrites the vector words.
    base = ack_cnt;
    set_inputs(32'hABCD_1234, 3'b011, 32'h0000_0001);
    model_entry(ret_pc, flags_in, sp_in);
    pulse();
    wait_acks(base + 1, 50);
    chk("wrap_sp", last_sp, 32'hFFFF_FFFE);
    chk("wrap_mem1", phys_rd(32'h1), 16'hABCD);
    chk("wrap_mem0", phys_rd(32'h0), 16'h1234);
    chk("wrap_memtop", phys_rd(32'hFFFF_FFFF), 16'h0003);
    chk("wrap_pc", last_pc, 32'h1234_ABCD);
    step(3);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

endmodule
